// File: rtl/fir_window_feeder.sv
// FIR-mode feeder for the 11-PE systolic array: holds the sample window and
// tap file, issues samples under a credit limit so array results always have
// a FIFO slot, and streams the captured results out with backpressure.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for ap_start; tap writes accepted
// S_RUN   | accepting input samples until `length` have been issued
// S_DRAIN | all samples issued; waiting for the last result to be popped
// S_DONE  | run complete; behaves as S_IDLE (restartable, taps writable)
module fir_window_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TAPS   = 11,
    parameter int ARRAY_LAT  = 2,
    parameter int RES_DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           cfg_tap_we,
    input  logic [3:0]                     cfg_tap_addr,
    input  logic [DATA_WIDTH-1:0]          cfg_tap_wdata,
    input  logic [31:0]                    cfg_data_length,
    input  logic                           ap_start,
    output logic                           ap_idle,
    output logic                           ap_done,
    input  logic                           ss_tvalid,
    input  logic [DATA_WIDTH-1:0]          ss_tdata,
    output logic                           ss_tready,
    output logic                           sm_tvalid,
    output logic [DATA_WIDTH-1:0]          sm_tdata,
    output logic                           sm_tlast,
    input  logic                           sm_tready,
    output logic                           func_sel,
    output logic [DATA_WIDTH*NUM_TAPS-1:0] fir_data,
    output logic [DATA_WIDTH*NUM_TAPS-1:0] fir_tap,
    input  logic [DATA_WIDTH-1:0]          fir_result
);

    localparam int PW = $clog2(RES_DEPTH);
    localparam int CW = $clog2(RES_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  done_d;
    logic [DATA_WIDTH-1:0] win_q [NUM_TAPS];
    logic [DATA_WIDTH-1:0] tap_q [NUM_TAPS];
    logic [31:0]           length_q, issued_q, emitted_q;
    logic [ARRAY_LAT-1:0]  tag_q;
    logic [DATA_WIDTH-1:0] fifo_mem [RES_DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         fifo_count_q;

    logic idle_st, start_ok, accept, push, pop, has_credit;
    int   inflight;

    assign idle_st   = (state_q == S_IDLE) || (state_q == S_DONE);
    assign start_ok  = idle_st && ap_start;
    assign ap_idle   = idle_st;
    assign func_sel  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign ss_tready = (state_q == S_RUN) && has_credit && (issued_q < length_q);
    assign accept    = ss_tvalid && ss_tready;
    // The oldest tag leaving the pipe marks fir_result as belonging to a window.
    assign push      = tag_q[ARRAY_LAT-1];
    assign sm_tvalid = (fifo_count_q != '0);
    assign sm_tdata  = fifo_mem[rd_ptr_q];
    assign sm_tlast  = sm_tvalid && (emitted_q == length_q - 32'd1);
    assign pop       = sm_tvalid && sm_tready;

    genvar g;
    generate
        for (g = 0; g < NUM_TAPS; g++) begin : g_pack
            assign fir_data[g*DATA_WIDTH +: DATA_WIDTH] = win_q[g];
            assign fir_tap[g*DATA_WIDTH +: DATA_WIDTH]  = tap_q[g];
        end
    endgenerate

    // Credit check: every in-flight tag will need a FIFO slot when it lands.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < ARRAY_LAT; i++) begin
            if (tag_q[i]) inflight = inflight + 1;
        end
        has_credit = (int'(fifo_count_q) + inflight) < RES_DEPTH;
    end

    // Next-state logic; ap_done is registered so it lands the cycle after the event.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (ap_start) begin
                    if (cfg_data_length == 32'd0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (issued_q == length_q) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (pop && sm_tlast) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register and done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ap_done <= 1'b0;
        end else begin
            state_q <= state_d;
            ap_done <= done_d;
        end
    end

    // Run bookkeeping, sample window and tap file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            length_q  <= '0;
            issued_q  <= '0;
            emitted_q <= '0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                win_q[k] <= '0;
                tap_q[k] <= '0;
            end
        end else begin
            if (start_ok) begin
                length_q  <= cfg_data_length;
                issued_q  <= '0;
                emitted_q <= '0;
                for (int k = 0; k < NUM_TAPS; k++) win_q[k] <= '0;
            end else begin
                if (accept) begin
                    win_q[0] <= ss_tdata;
                    for (int k = 1; k < NUM_TAPS; k++) win_q[k] <= win_q[k-1];
                    issued_q <= issued_q + 32'd1;
                end
                if (pop) emitted_q <= emitted_q + 32'd1;
            end
            if (idle_st && cfg_tap_we) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    if (cfg_tap_addr == 4'(k)) tap_q[k] <= cfg_tap_wdata;
                end
            end
        end
    end

    // Tag pipe mirrors the array latency and result FIFO absorbs its output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fifo_count_q <= '0;
            for (int i = 0; i < RES_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            tag_q[0] <= accept;
            for (int i = 1; i < ARRAY_LAT; i++) tag_q[i] <= tag_q[i-1];
            if (push) begin
                fifo_mem[wr_ptr_q] <= fir_result;
                wr_ptr_q <= (wr_ptr_q == PW'(RES_DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(RES_DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
            end
            if (push && !pop)      fifo_count_q <= fifo_count_q + CW'(1);
            else if (pop && !push) fifo_count_q <= fifo_count_q - CW'(1);
        end
    end

endmodule

// File: tb/tb_fir_window_feeder.sv
// Directed bench for fir_window_feeder with a behavioural array model.
module tb_fir_window_feeder;

    localparam int DW = 32;
    localparam int NT = 11;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            cfg_tap_we;
    logic [3:0]      cfg_tap_addr;
    logic [DW-1:0]   cfg_tap_wdata;
    logic [31:0]     cfg_data_length;
    logic            ap_start;
    logic            ap_idle, ap_done;
    logic            ss_tvalid;
    logic [DW-1:0]   ss_tdata;
    logic            ss_tready;
    logic            sm_tvalid;
    logic [DW-1:0]   sm_tdata;
    logic            sm_tlast;
    logic            sm_tready;
    logic            func_sel;
    logic [DW*NT-1:0] fir_data, fir_tap;
    logic [DW-1:0]   fir_result;
    logic [DW-1:0]   arr_q = '0;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] xs[$];
    logic [31:0] exp_y[$];

    fir_window_feeder dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_tap_we(cfg_tap_we), .cfg_tap_addr(cfg_tap_addr), .cfg_tap_wdata(cfg_tap_wdata),
        .cfg_data_length(cfg_data_length), .ap_start(ap_start),
        .ap_idle(ap_idle), .ap_done(ap_done),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tready(ss_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready),
        .func_sel(func_sel), .fir_data(fir_data), .fir_tap(fir_tap), .fir_result(fir_result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dot(input logic [DW*NT-1:0] d, input logic [DW*NT-1:0] t);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < NT; k++) s = s + d[k*DW +: DW] * t[k*DW +: DW];
        return s;
    endfunction

    // Array model: dot product of the driven window, one register stage.
    always @(posedge clk) arr_q <= dot(fir_data, fir_tap);
    assign fir_result = arr_q;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Result FIFO must never exceed its depth.
    always @(negedge clk) begin
        if (rst_n) chk("fifo_bound", 64'(dut.fifo_count_q <= 4), 64'd1);
    end

    task automatic write_tap(input int addr, input logic [31:0] val);
        @(negedge clk);
        cfg_tap_we = 1'b1; cfg_tap_addr = 4'(addr); cfg_tap_wdata = val;
        @(negedge clk);
        cfg_tap_we = 1'b0;
    endtask

    task automatic impulse_setup(input int len);
        for (int k = 0; k < NT; k++) write_tap(k, 32'(k + 1));
        xs.delete(); exp_y.delete();
        for (int i = 0; i < len; i++) begin
            xs.push_back(i == 0 ? 32'd1 : 32'd0);
            exp_y.push_back(i < NT ? 32'(i + 1) : 32'd0);
        end
    endtask

    task automatic do_run(input int len, input int stall, input bit poke, input bit thru, input string nm);
        logic [31:0] got_v[$];
        bit          got_l[$];
        int cyc, ni, last_pop, done_cyc, acc_stall, first_acc, last_acc, n_acc;
        bit done_seen;
        @(negedge clk);
        cfg_data_length = 32'(len); ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        cyc = 0; ni = 0; last_pop = -10; done_cyc = -1; acc_stall = 0;
        first_acc = -1; last_acc = -1; n_acc = 0; done_seen = 0;
        while (!done_seen && cyc < 500) begin
            sm_tready  = (cyc >= stall);
            ss_tvalid  = (ni < len);
            ss_tdata   = (ni < len) ? xs[ni] : 32'd0;
            cfg_tap_we = poke && (cyc == 3);
            cfg_tap_addr = 4'd0; cfg_tap_wdata = 32'd99;
            #1;
            if (cyc == 1) chk({nm, "_func_sel"}, 64'(func_sel), 64'd1);
            if (ap_done) begin
                done_seen = 1; done_cyc = cyc;
            end else begin
                if (ss_tvalid && ss_tready) begin
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc; n_acc++; ni++;
                    if (cyc < stall) acc_stall++;
                end
                if (sm_tvalid && sm_tready) begin
                    got_v.push_back(sm_tdata); got_l.push_back(sm_tlast); last_pop = cyc;
                end
            end
            @(negedge clk);
            cyc++;
        end
        ss_tvalid = 1'b0; cfg_tap_we = 1'b0;
        chk({nm, "_done_seen"}, 64'(done_seen), 64'd1);
        chk({nm, "_done_lat"}, 64'(done_cyc - last_pop), 64'd1);
        chk({nm, "_n_acc"}, 64'(n_acc), 64'(len));
        chk({nm, "_n_res"}, 64'(got_v.size()), 64'(len));
        for (int i = 0; i < len && i < got_v.size(); i++) begin
            chk($sformatf("%s_y%0d", nm, i), 64'(got_v[i]), 64'(exp_y[i]));
            chk($sformatf("%s_last%0d", nm, i), 64'(got_l[i]), 64'(i == len - 1));
        end
        if (stall > 0) chk({nm, "_acc_in_stall"}, 64'(acc_stall), 64'd4);
        if (thru) chk({nm, "_span"}, 64'(last_acc - first_acc), 64'(len - 1));
        chk({nm, "_idle_after"}, 64'(ap_idle), 64'd1);
        chk({nm, "_fsel_after"}, 64'(func_sel), 64'd0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_idle"}, 64'(ap_idle), 64'd1);
        chk({nm, "_done"}, 64'(ap_done), 64'd0);
        chk({nm, "_tready"}, 64'(ss_tready), 64'd0);
        chk({nm, "_tvalid"}, 64'(sm_tvalid), 64'd0);
        chk({nm, "_tlast"}, 64'(sm_tlast), 64'd0);
        chk({nm, "_fsel"}, 64'(func_sel), 64'd0);
        chk({nm, "_taps_zero"}, 64'(fir_tap == '0), 64'd1);
        chk({nm, "_win_zero"}, 64'(fir_data == '0), 64'd1);
    endtask

    initial begin
        logic [DW*NT-1:0] exp_taps;
        int saw_tr, saw_v, n_done, idle_low, acc;
        rst_n = 1'b0; cfg_tap_we = 1'b0; cfg_tap_addr = '0; cfg_tap_wdata = '0;
        cfg_data_length = '0; ap_start = 1'b0; ss_tvalid = 1'b0; ss_tdata = '0; sm_tready = 1'b0;
        #23;
        chk_reset_outputs("reset");
        @(negedge clk); rst_n = 1'b1;

        // Impulse response with a tap write attempted mid-run.
        impulse_setup(12);
        do_run(12, 0, 1'b1, 1'b1, "impulse");
        chk("tap0_after_run_write", 64'(fir_tap[31:0]), 64'd1);

        // Out-of-range tap addresses while idle are ignored.
        write_tap(12, 32'd77);
        write_tap(11, 32'd55);
        exp_taps = '0;
        for (int k = 0; k < NT; k++) exp_taps[k*DW +: DW] = 32'(k + 1);
        chk("tap_oob_ignored", 64'(fir_tap == exp_taps), 64'd1);

        // Backpressure: downstream stalled for the first 10 cycles.
        do_run(12, 10, 1'b0, 1'b0, "bp");

        // Zero-length run.
        @(negedge clk);
        cfg_data_length = 32'd0; ap_start = 1'b1;
        #1;
        idle_low = (ap_idle == 1'b0);
        @(negedge clk);
        ap_start = 1'b0;
        saw_tr = 0; saw_v = 0; n_done = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (ss_tready) saw_tr++;
            if (sm_tvalid) saw_v++;
            if (ap_done) n_done++;
            if (!ap_idle) idle_low++;
            @(negedge clk);
        end
        chk("zero_tready", 64'(saw_tr), 64'd0);
        chk("zero_tvalid", 64'(saw_v), 64'd0);
        chk("zero_done_cnt", 64'(n_done), 64'd1);
        chk("zero_idle_low", 64'(idle_low), 64'd0);

        // Wrap-around arithmetic.
        write_tap(0, 32'd2);
        for (int k = 1; k < NT; k++) write_tap(k, 32'd0);
        xs.delete(); exp_y.delete();
        xs.push_back(32'h7FFF_FFFF); exp_y.push_back(32'hFFFF_FFFE);
        do_run(1, 0, 1'b0, 1'b0, "wrap");

        // Reset in the middle of a run, then restart.
        impulse_setup(12);
        @(negedge clk);
        cfg_data_length = 32'd12; ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        acc = 0;
        for (int i = 0; i < 50 && acc < 5; i++) begin
            ss_tvalid = 1'b1; ss_tdata = xs[acc]; sm_tready = 1'b1;
            #1;
            if (ss_tready) acc++;
            @(negedge clk);
        end
        chk("midrst_accepts", 64'(acc), 64'd5);
        ss_tvalid = 1'b0;
        #1;
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("midrst");
        @(negedge clk); rst_n = 1'b1;
        impulse_setup(3);
        do_run(3, 0, 1'b0, 1'b0, "restart");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
